// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, default width and the combinational compute/carry helpers
// used by both the combinational ALU and alu_cmd_responder.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  function automatic logic [ALU_WIDTH-1:0] alu_compute(input logic [2:0]           op,
                                                       input logic [ALU_WIDTH-1:0] a,
                                                       input logic [ALU_WIDTH-1:0] b);
    logic [ALU_WIDTH-1:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_NOT: r = ~a;
      ALU_SHL: r = a << b[2:0];
      ALU_SHR: r = a >> b[2:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  // Carry-out for ADD, borrow (A<B) for SUB, zero for everything else.
  function automatic logic alu_carry(input logic [2:0]           op,
                                     input logic [ALU_WIDTH-1:0] a,
                                     input logic [ALU_WIDTH-1:0] b);
    logic [ALU_WIDTH:0] sum;
    logic               c;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      ALU_ADD: c = sum[ALU_WIDTH];
      ALU_SUB: c = (a < b);
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_resp_fifo.sv
// Generic synchronous FIFO, async active-high reset. Pointers carry one extra wrap bit so
// full/empty come straight from the registered pointers.
module alu_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_s;
  logic         pop_s;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/alu_cmd_responder.sv
// Handshaked ALU responder: computes on accept, queues results in order, counts accepts.
// Optional per-result zero/carry flags when ALU_RESP_FLAGS_EN is defined.
module alu_cmd_responder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_op,
`ifdef ALU_RESP_FLAGS_EN
  output logic [1:0]       rsp_flags,
`endif
  output logic [15:0]      cmd_count
);

  // The shared compute function is fixed to the package width.
  if (WIDTH != ALU_WIDTH) begin : g_width_check
    $error("alu_cmd_responder: WIDTH must equal alu_pkg::ALU_WIDTH");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("alu_cmd_responder: DEPTH must be a power of two and at least 2");
  end

`ifdef ALU_RESP_FLAGS_EN
  localparam int EW = WIDTH + 3 + 2;
`else
  localparam int EW = WIDTH + 3;
`endif

  logic [WIDTH-1:0] result_s;
  logic [EW-1:0]    push_data_s;
  logic [EW-1:0]    head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             accept_s;
  logic             pop_s;
  logic [15:0]      cmd_count_q, cmd_count_d;

  assign result_s  = alu_compute(cmd_op, cmd_a, cmd_b);
  assign cmd_ready = !fifo_full_s;
  assign rsp_valid = !fifo_empty_s;
  assign accept_s  = cmd_valid && cmd_ready;
  assign pop_s     = rsp_valid && rsp_ready;
  assign cmd_count = cmd_count_q;

`ifdef ALU_RESP_FLAGS_EN
  assign push_data_s = {alu_carry(cmd_op, cmd_a, cmd_b), (result_s == {WIDTH{1'b0}}), cmd_op, result_s};
  assign {rsp_flags, rsp_op, rsp_result} = head_s;
`else
  assign push_data_s = {cmd_op, result_s};
  assign {rsp_op, rsp_result} = head_s;
`endif

  alu_resp_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept_s),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  always_comb begin
    cmd_count_d = cmd_count_q;
    if (accept_s) begin
      cmd_count_d = cmd_count_q + 16'd1;
    end else begin
      cmd_count_d = cmd_count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_count_q <= 16'd0;
    end else begin
      cmd_count_q <= cmd_count_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Self-checking bench for alu_cmd_responder: table-driven vectors feeding an in-order scoreboard,
// plus hand-written back-pressure, streaming and reset sequences.
module tb_alu_cmd_responder;
  import alu_pkg::*;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [1:0] flg;
  } vec_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] res;
    logic [1:0] flg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [7:0]  cmd_a = 8'd0;
  logic [7:0]  cmd_b = 8'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_result;
  logic [2:0]  rsp_op;
  logic [15:0] cmd_count;
`ifdef ALU_RESP_FLAGS_EN
  logic [1:0]  rsp_flags;
`endif

  exp_t cur_exp;
  exp_t mon_e;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   acc_cnt = 0;

  always #5 clk = ~clk;

  alu_cmd_responder #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
`ifdef ALU_RESP_FLAGS_EN
    .rsp_flags  (rsp_flags),
`endif
    .cmd_count  (cmd_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: handshakes are decided by values stable at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got result 0x%0h, expected no response", rsp_result);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_result", rsp_result, mon_e.res);
          check("rsp_op", rsp_op, mon_e.op);
`ifdef ALU_RESP_FLAGS_EN
          check("rsp_flags", rsp_flags, mon_e.flg);
`endif
        end
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(cur_exp);
        acc_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    cmd_op    = v.op;
    cmd_a     = v.a;
    cmd_b     = v.b;
    cur_exp   = '{op: v.op, res: v.res, flg: v.flg};
    cmd_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    int n;
    n = 0;
    drive(v);
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got cmd_ready=0 for %0d cycles, expected acceptance", n);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      tick();
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t sweep[10];
    vec_t bp[5];
    vec_t v;
    int   base;

    sweep[0] = '{ALU_ADD, 8'hF0, 8'h03, 8'hF3, 2'b00};
    sweep[1] = '{ALU_SUB, 8'hF0, 8'h03, 8'hED, 2'b00};
    sweep[2] = '{ALU_AND, 8'hF0, 8'h03, 8'h00, 2'b01};
    sweep[3] = '{ALU_OR,  8'hF0, 8'h03, 8'hF3, 2'b00};
    sweep[4] = '{ALU_XOR, 8'hF0, 8'h03, 8'hF3, 2'b00};
    sweep[5] = '{ALU_NOT, 8'hF0, 8'h03, 8'h0F, 2'b00};
    sweep[6] = '{ALU_SHL, 8'hF0, 8'h03, 8'h80, 2'b00};
    sweep[7] = '{ALU_SHR, 8'hF0, 8'h03, 8'h1E, 2'b00};
    sweep[8] = '{ALU_ADD, 8'hFF, 8'h01, 8'h00, 2'b11};
    sweep[9] = '{ALU_SUB, 8'h01, 8'h02, 8'hFF, 2'b10};

    bp[0] = '{ALU_ADD, 8'h01, 8'h02, 8'h03, 2'b00};
    bp[1] = '{ALU_SUB, 8'h0A, 8'h03, 8'h07, 2'b00};
    bp[2] = '{ALU_XOR, 8'h55, 8'hFF, 8'hAA, 2'b00};
    bp[3] = '{ALU_OR,  8'h0F, 8'h30, 8'h3F, 2'b00};
    bp[4] = '{ALU_SHR, 8'h81, 8'h09, 8'h40, 2'b00};

    // Reset state
    repeat (3) tick();
    check("rst_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_op", rsp_op, 0);
    check("rst_cmd_count", cmd_count, 0);
    tick();

    // Single command, one-cycle latency
    rsp_ready = 1'b1;
    v = '{ALU_ADD, 8'h04, 8'h04, 8'h08, 2'b00};
    send(v);
    check("lat_rsp_valid", rsp_valid, 1);
    check("lat_rsp_result", rsp_result, 8'h08);
    check("lat_rsp_op", rsp_op, 0);
    check("lat_cmd_count", cmd_count, 1);
    tick();
    check("lat_popped_valid", rsp_valid, 0);

    // Op sweep, back to back
    for (int i = 0; i < 10; i++) begin
      send(sweep[i]);
    end
    drain();
    check("sweep_cmd_count", cmd_count, 11);

    // Back-pressure: fifth command held until a pop frees a slot
    rsp_ready = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      send(bp[i]);
    end
    check("bp_full_ready", cmd_ready, 0);
    drive(bp[4]);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_held_ready", cmd_ready, 0);
    end
    check("bp_held_count", cmd_count, base + 4);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_ready_after_pop", cmd_ready, 1);
    check("bp_count_before", cmd_count, base + 4);
    tick();
    cmd_valid = 1'b0;
    check("bp_count_after", cmd_count, base + 5);
    check("bp_full_again", cmd_ready, 0);
    drain();

    // Simultaneous push/pop at occupancy 2
    rsp_ready = 1'b0;
    v = '{ALU_ADD, 8'h11, 8'h22, 8'h33, 2'b00};
    send(v);
    v = '{ALU_AND, 8'h40, 8'h0C, 8'h00, 2'b01};
    send(v);
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v.op  = ALU_ADD;
      v.a   = 8'(i * 5);
      v.b   = 8'(i * 3);
      v.res = 8'(i * 8);
      v.flg = (i == 0) ? 2'b01 : 2'b00;
      send(v);
      check("stream_valid", rsp_valid, 1);
      check("stream_ready", cmd_ready, 1);
    end
    rsp_ready = 1'b0;
    check("stream_occ2_a", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    check("stream_occ2_b", rsp_valid, 1);
    tick();
    check("stream_occ2_empty", rsp_valid, 0);
    check("stream_queue_empty", exp_q.size(), 0);

    // Asynchronous reset with three entries queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(sweep[i]);
    end
    check("pre_rst_valid", rsp_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_valid", rsp_valid, 0);
    check("rst_async_count", cmd_count, 0);
    exp_q.delete();
    acc_cnt = 0;
    tick();
    tick();
    rst = 1'b0;
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_count", cmd_count, 0);
    check("post_rst_valid", rsp_valid, 0);

    // Operation resumes cleanly after reset
    rsp_ready = 1'b1;
    send(sweep[8]);
    send(sweep[9]);
    drain();
    check("final_cmd_count", cmd_count, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
